// File: rtl/ex_hazard_ctrl_pkg.sv
// rtl/ex_hazard_ctrl_pkg.sv - shared state encoding, forwarding selects and compare helper
package ex_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_EX_BUSY  = 2'b01,
        ST_MEM_WAIT = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // MEM is the younger producer, so it wins over WB; x0 is never a real producer.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return FWD_MEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// rtl/ex_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface ex_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_mc_start;
    logic             ex_mc_done;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic             mem_branch;
    logic             mem_zero;
    logic             mem_jal;
    logic             mem_jalr;
    logic             mem_access;
    logic             dmem_ready;
    logic [4:0]       wb_rd;
    logic             wb_regwrite;

    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             idex_bubble;
    logic             flush;
    logic             pc_redirect;
    logic             exmem_bubble;
    logic             memwb_write;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline datapath side.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_memread, ex_mc_start, ex_mc_done,
        output mem_rd, mem_regwrite, mem_branch, mem_zero, mem_jal, mem_jalr,
        output mem_access, dmem_ready, wb_rd, wb_regwrite,
        input  ForwardA, ForwardB, pc_write, ifid_write, idex_write, idex_bubble,
        input  flush, pc_redirect, exmem_bubble, memwb_write, err_timeout,
        input  stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_memread, ex_mc_start, ex_mc_done,
        input  mem_rd, mem_regwrite, mem_branch, mem_zero, mem_jal, mem_jalr,
        input  mem_access, dmem_ready, wb_rd, wb_regwrite,
        output ForwardA, ForwardB, pc_write, ifid_write, idex_write, idex_bubble,
        output flush, pc_redirect, exmem_bubble, memwb_write, err_timeout,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
// rtl/ex_hazard_ctrl_fwd_unit.sv - combinational EX operand forwarding select
module fwd_unit
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    assign fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage hazard sequencer: forwarding, stalls, flushes, perf counters
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    ex_hazard_ctrl_if.slave hz
);

    localparam int TMR_W = $clog2(MC_TIMEOUT + 1);

    hz_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall_inc, flush_inc;
    logic [1:0]       fwd_a, fwd_b;
    logic             redirect, load_use, mem_stall;

    fwd_unit u_fwd (
        .ex_rs1       (hz.ex_rs1),
        .ex_rs2       (hz.ex_rs2),
        .mem_rd       (hz.mem_rd),
        .mem_regwrite (hz.mem_regwrite),
        .wb_rd        (hz.wb_rd),
        .wb_regwrite  (hz.wb_regwrite),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    assign redirect  = (hz.mem_branch && hz.mem_zero) || hz.mem_jal || hz.mem_jalr;
    assign load_use  = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                       ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                        (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    assign mem_stall = hz.mem_access && !hz.dmem_ready;

    assign hz.ForwardA    = reset ? fwd_a : FWD_NONE;
    assign hz.ForwardB    = reset ? fwd_b : FWD_NONE;
    assign hz.err_timeout = err_q;
    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        pend_d          = pend_q;
        err_d           = err_q;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.idex_write   = 1'b1;
        hz.idex_bubble  = 1'b0;
        hz.flush        = 1'b0;
        hz.pc_redirect  = 1'b0;
        hz.exmem_bubble = 1'b0;
        hz.memwb_write  = 1'b1;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    // A redirect seen while dmem stalls is replayed on the exit cycle.
                    state_d        = ST_MEM_WAIT;
                    pend_d         = redirect;
                    stall_inc      = 1'b1;
                    hz.pc_write    = 1'b0;
                    hz.ifid_write  = 1'b0;
                    hz.idex_write  = 1'b0;
                    hz.memwb_write = 1'b0;
                end else if (redirect) begin
                    flush_inc      = 1'b1;
                    hz.flush       = 1'b1;
                    hz.pc_redirect = 1'b1;
                end else if (hz.ex_mc_start) begin
                    state_d         = ST_EX_BUSY;
                    timer_d         = TMR_W'(1);
                    stall_inc       = 1'b1;
                    hz.pc_write     = 1'b0;
                    hz.ifid_write   = 1'b0;
                    hz.idex_write   = 1'b0;
                    hz.exmem_bubble = 1'b1;
                end else if (load_use) begin
                    stall_inc      = 1'b1;
                    hz.pc_write    = 1'b0;
                    hz.ifid_write  = 1'b0;
                    hz.idex_bubble = 1'b1;
                end
            end
            ST_EX_BUSY: begin
                if (hz.ex_mc_done) begin
                    state_d = ST_RUN;
                end else begin
                    stall_inc       = 1'b1;
                    hz.pc_write     = 1'b0;
                    hz.ifid_write   = 1'b0;
                    hz.idex_write   = 1'b0;
                    hz.exmem_bubble = 1'b1;
                    // Timer saturates so a hung unit keeps the flag without wrapping.
                    if (timer_q == TMR_W'(MC_TIMEOUT)) begin
                        err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_d = ST_RUN;
                    if (pend_q) begin
                        pend_d         = 1'b0;
                        flush_inc      = 1'b1;
                        hz.flush       = 1'b1;
                        hz.pc_redirect = 1'b1;
                    end
                end else begin
                    stall_inc      = 1'b1;
                    hz.pc_write    = 1'b0;
                    hz.ifid_write  = 1'b0;
                    hz.idex_write  = 1'b0;
                    hz.memwb_write = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!reset) begin
            stall_inc       = 1'b0;
            flush_inc       = 1'b0;
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_write   = 1'b0;
            hz.idex_bubble  = 1'b0;
            hz.flush        = 1'b0;
            hz.pc_redirect  = 1'b0;
            hz.exmem_bubble = 1'b0;
            hz.memwb_write  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            timer_q <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            stall_q <= stall_q + CNT_W'(stall_inc);
            flush_q <= flush_q + CNT_W'(flush_inc);
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - scoreboard bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;
    import ex_hazard_ctrl_pkg::*;

    localparam int CNT_W = 32;
    // {pc_write, ifid_write, idex_write, idex_bubble, flush, pc_redirect, exmem_bubble, memwb_write}
    localparam logic [7:0] C_RUN  = 8'hE1;
    localparam logic [7:0] C_LU   = 8'h31;
    localparam logic [7:0] C_RDR  = 8'hED;
    localparam logic [7:0] C_BUSY = 8'h03;
    localparam logic [7:0] C_FRZ  = 8'h00;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] ctrl;
        logic       err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    ex_hazard_ctrl #(.MC_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ctrl_obs();
        return {hz.pc_write, hz.ifid_write, hz.idex_write, hz.idex_bubble,
                hz.flush, hz.pc_redirect, hz.exmem_bubble, hz.memwb_write};
    endfunction

    // Inputs are set at posedge+1; outputs are checked at the following negedge.
    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [7:0] ctrl, input logic err);
        exp_t e;
        exp_t g;
        e = {fa, fb, ctrl, err};
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        check({tag, ".fa"},   32'(hz.ForwardA),    32'(g.fa));
        check({tag, ".fb"},   32'(hz.ForwardB),    32'(g.fb));
        check({tag, ".ctrl"}, 32'(ctrl_obs()),     32'(g.ctrl));
        check({tag, ".err"},  32'(hz.err_timeout), 32'(g.err));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_rs1 = 0; hz.ex_rs2 = 0; hz.ex_rd = 0; hz.ex_memread = 0;
        hz.ex_mc_start = 0; hz.ex_mc_done = 0;
        hz.mem_rd = 0; hz.mem_regwrite = 0; hz.mem_branch = 0; hz.mem_zero = 0;
        hz.mem_jal = 0; hz.mem_jalr = 0; hz.mem_access = 0; hz.dmem_ready = 0;
        hz.wb_rd = 0; hz.wb_regwrite = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step("rst", FWD_NONE, FWD_NONE, C_FRZ, 1'b0);
        check("rst.stall_cnt", hz.stall_cnt, 0);
        check("rst.flush_cnt", hz.flush_cnt, 0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        idle();
        do_reset();
        step("idle", FWD_NONE, FWD_NONE, C_RUN, 1'b0);

        // Forwarding priority and x0 handling
        hz.ex_rs1 = 5; hz.ex_rs2 = 5; hz.mem_rd = 5; hz.mem_regwrite = 1;
        hz.wb_rd = 5; hz.wb_regwrite = 1;
        step("fwd_mem_over_wb", FWD_MEM, FWD_MEM, C_RUN, 1'b0);
        hz.mem_rd = 0;
        step("fwd_mem_x0_wb", FWD_WB, FWD_WB, C_RUN, 1'b0);
        hz.wb_regwrite = 0;
        step("fwd_mem_x0", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        hz.ex_rs2 = 7; hz.mem_rd = 7; hz.wb_regwrite = 1;
        step("fwd_split", FWD_WB, FWD_MEM, C_RUN, 1'b0);
        hz.mem_regwrite = 0;
        step("fwd_no_regwrite", FWD_WB, FWD_NONE, C_RUN, 1'b0);
        hz.ex_rs1 = 0; hz.wb_rd = 0;
        step("fwd_wb_x0", FWD_NONE, FWD_NONE, C_RUN, 1'b0);

        // Load-use: one bubble, then WB forward
        idle(); hz.ex_memread = 1; hz.ex_rd = 3; hz.id_rs1 = 3; hz.id_use_rs1 = 1;
        step("lu_stall", FWD_NONE, FWD_NONE, C_LU, 1'b0);
        check("lu.stall_cnt", hz.stall_cnt, 1);
        idle(); hz.mem_rd = 3; hz.mem_regwrite = 1; hz.id_rs1 = 3; hz.id_use_rs1 = 1;
        step("lu_drain", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        idle(); hz.ex_rs1 = 3; hz.wb_rd = 3; hz.wb_regwrite = 1;
        step("lu_fwd", FWD_WB, FWD_NONE, C_RUN, 1'b0);
        check("lu_after.stall_cnt", hz.stall_cnt, 1);
        idle(); hz.ex_memread = 1; hz.ex_rd = 3; hz.id_rs2 = 3; hz.id_rs1 = 4; hz.id_use_rs1 = 1;
        step("lu_unused_rs2", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        hz.ex_rd = 0; hz.id_rs1 = 0;
        step("lu_x0", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        hz.ex_rd = 9; hz.id_rs2 = 9; hz.id_use_rs2 = 1;
        step("lu_rs2", FWD_NONE, FWD_NONE, C_LU, 1'b0);
        check("lu_rs2.stall_cnt", hz.stall_cnt, 2);

        // Redirect beats load-use and mc_start
        do_reset();
        hz.mem_branch = 1; hz.mem_zero = 1; hz.ex_memread = 1; hz.ex_rd = 3;
        hz.id_rs1 = 3; hz.id_use_rs1 = 1; hz.ex_mc_start = 1;
        step("br_taken", FWD_NONE, FWD_NONE, C_RDR, 1'b0);
        check("br.flush_cnt", hz.flush_cnt, 1);
        check("br.stall_cnt", hz.stall_cnt, 0);
        idle();
        step("br_after", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        hz.mem_branch = 1;
        step("br_not_taken", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        idle(); hz.mem_jalr = 1;
        step("jalr", FWD_NONE, FWD_NONE, C_RDR, 1'b0);
        idle(); hz.mem_jal = 1;
        step("jal", FWD_NONE, FWD_NONE, C_RDR, 1'b0);
        check("jal.flush_cnt", hz.flush_cnt, 3);

        // Multi-cycle op, done after 5 cycles (timeout 4 is crossed first)
        do_reset();
        hz.ex_mc_start = 1;
        step("mc_start", FWD_NONE, FWD_NONE, C_BUSY, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) step("mc_busy", FWD_NONE, FWD_NONE, C_BUSY, 1'b0);
        hz.ex_mc_done = 1;
        step("mc_done", FWD_NONE, FWD_NONE, C_RUN, 1'b1);
        idle();
        step("mc_run", FWD_NONE, FWD_NONE, C_RUN, 1'b1);
        check("mc.stall_cnt", hz.stall_cnt, 5);

        // Done exactly at timer==MC_TIMEOUT: no error
        do_reset();
        hz.ex_mc_start = 1;
        step("mc4_start", FWD_NONE, FWD_NONE, C_BUSY, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) step("mc4_busy", FWD_NONE, FWD_NONE, C_BUSY, 1'b0);
        hz.ex_mc_done = 1;
        step("mc4_done", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        idle();
        step("mc4_run", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        check("mc4.stall_cnt", hz.stall_cnt, 4);

        // Redirect during dmem wait is deferred to the ready cycle
        do_reset();
        hz.mem_branch = 1; hz.mem_zero = 1; hz.mem_access = 1;
        for (int i = 0; i < 3; i++) step("mw_wait", FWD_NONE, FWD_NONE, C_FRZ, 1'b0);
        check("mw_wait.flush_cnt", hz.flush_cnt, 0);
        hz.dmem_ready = 1;
        step("mw_ready", FWD_NONE, FWD_NONE, C_RDR, 1'b0);
        check("mw.flush_cnt", hz.flush_cnt, 1);
        check("mw.stall_cnt", hz.stall_cnt, 3);
        idle(); hz.mem_access = 1; hz.dmem_ready = 1;
        step("mw_hit", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        hz.dmem_ready = 0;
        step("mw2_wait", FWD_NONE, FWD_NONE, C_FRZ, 1'b0);
        hz.dmem_ready = 1;
        step("mw2_ready", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        check("mw2.flush_cnt", hz.flush_cnt, 1);
        check("mw2.stall_cnt", hz.stall_cnt, 4);

        // Reset inside EX_BUSY, then a real timeout
        do_reset();
        hz.ex_mc_start = 1;
        step("rm_start", FWD_NONE, FWD_NONE, C_BUSY, 1'b0);
        idle();
        step("rm_busy", FWD_NONE, FWD_NONE, C_BUSY, 1'b0);
        reset = 1'b0; hz.ex_rs1 = 5; hz.mem_rd = 5; hz.mem_regwrite = 1;
        step("rm_reset", FWD_NONE, FWD_NONE, C_FRZ, 1'b0);
        check("rm.stall_cnt", hz.stall_cnt, 0);
        reset = 1'b1; idle();
        step("rm_run", FWD_NONE, FWD_NONE, C_RUN, 1'b0);
        hz.ex_mc_start = 1;
        step("to_start", FWD_NONE, FWD_NONE, C_BUSY, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) step("to_busy", FWD_NONE, FWD_NONE, C_BUSY, 1'b0);
        for (int i = 0; i < 2; i++) step("to_err", FWD_NONE, FWD_NONE, C_BUSY, 1'b1);
        hz.ex_mc_done = 1;
        step("to_done", FWD_NONE, FWD_NONE, C_RUN, 1'b1);
        do_reset();
        step("to_cleared", FWD_NONE, FWD_NONE, C_RUN, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
